// File: rtl/prog_loader_pkg.sv
// Shared loader definitions: frame sync byte, loader FSM encoding, word geometry.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package prog_loader_pkg;

  // First byte of every load frame; anything else seen while idle is dropped.
  localparam logic [7:0] LOADER_SYNC = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_COUNT,
    ST_DATA,
    ST_CKSUM
  } loader_state_t;

  // Number of stream bytes making up one instruction word.
  function automatic int unsigned bytes_per_word(input int unsigned word_width);
    return word_width / 8;
  endfunction

  localparam int unsigned LOADER_WORD_WIDTH = 24;
  localparam int unsigned LOADER_BPW        = bytes_per_word(LOADER_WORD_WIDTH);

endpackage

// File: rtl/prog_loader_if.sv
// Host byte stream plus program-memory write port and loader status.
// Latency: n/a (signal bundle only).
// Backpressure: in_ready gates the byte stream; the write port has none.
// Ports: in_data/in_valid/in_ready (byte stream), wr_en/wr_addr/wr_data
// (memory write), cpu_hold/done/err (status).
interface prog_loader_if #(
  parameter int RAM_WORD_WIDTH = 24,
  parameter int RAM_ADDR_BITS  = 8
);
  logic [7:0]                in_data;
  logic                      in_valid;
  logic                      in_ready;
  logic                      wr_en;
  logic [RAM_ADDR_BITS-1:0]  wr_addr;
  logic [RAM_WORD_WIDTH-1:0] wr_data;
  logic                      cpu_hold;
  logic                      done;
  logic                      err;

  // Host side: drives bytes, observes the memory port and status.
  modport master (
    output in_data, in_valid,
    input  in_ready, wr_en, wr_addr, wr_data, cpu_hold, done, err
  );

  // Loader side.
  modport slave (
    input  in_data, in_valid,
    output in_ready, wr_en, wr_addr, wr_data, cpu_hold, done, err
  );
endinterface

// File: rtl/prog_loader_word_pack.sv
// Packs accepted bytes MSB-first into a word and presents it with a 1-cycle valid.
// Latency: o_word_vld/o_word register one cycle after the word's final byte.
// Backpressure: none; every i_byte_vld byte is absorbed.
// Ports: i_clr restarts byte alignment, i_byte_vld/i_byte byte input,
// o_last marks that the current input byte completes a word, o_word_vld/o_word result.
module prog_loader_word_pack
  import prog_loader_pkg::*;
#(
  parameter int WORD_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_clr,
  input  logic                  i_byte_vld,
  input  logic [7:0]            i_byte,
  output logic                  o_last,
  output logic                  o_word_vld,
  output logic [WORD_WIDTH-1:0] o_word
);

  localparam int BPW = int'(bytes_per_word(WORD_WIDTH));
  localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;

  logic [CW-1:0]         r_cnt;
  logic [WORD_WIDTH-1:0] r_shift;
  logic [WORD_WIDTH-1:0] r_word;
  logic                  r_word_vld;
  logic [WORD_WIDTH-1:0] w_shifted;

  // Oldest byte falls off the top; works for single-byte words as well.
  assign w_shifted = WORD_WIDTH'({r_shift, i_byte});
  assign o_last    = (r_cnt == CW'(BPW - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_shift    <= '0;
      r_word     <= '0;
      r_word_vld <= 1'b0;
    end else begin
      r_word_vld <= 1'b0;
      if (i_clr) begin
        r_cnt   <= '0;
        r_shift <= '0;
      end else if (i_byte_vld) begin
        r_shift <= w_shifted;
        if (o_last) begin
          r_cnt      <= '0;
          r_word_vld <= 1'b1;
          // Held until the next word so wr_data stays stable with wr_en.
          r_word     <= w_shifted;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign o_word_vld = r_word_vld;
  assign o_word     = r_word;

endmodule

// File: rtl/prog_loader.sv
// Framed byte-stream program loader writing instruction words to program RAM.
// Latency: write 1 cycle after a word's last byte; done/err 1 cycle after CKSUM.
// Backpressure: none; in_ready is high in every state after reset.
// Ports: clk, rst_n (async active-low); bus (slave modport): byte stream in,
// program-memory write port out, cpu_hold/done/err status out.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int RAM_WORD_WIDTH = 24,
  parameter int RAM_ADDR_BITS  = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  prog_loader_if.slave  bus
);

  loader_state_t            r_state;
  logic [RAM_ADDR_BITS-1:0] r_addr;
  logic [8:0]               r_wcnt;   // 9 bits: COUNT of 0 means 256 words
  logic [7:0]               r_cksum;
  logic                     r_in_ready;
  logic                     r_hold;
  logic                     r_done;
  logic                     r_err;

  logic                      w_fire;
  logic                      w_sync;
  logic                      w_data_byte;
  logic                      w_last;
  logic                      w_word_vld;
  logic [RAM_WORD_WIDTH-1:0] w_word;

  assign w_fire      = bus.in_valid && r_in_ready;
  assign w_sync      = w_fire && (r_state == ST_IDLE) && (bus.in_data == LOADER_SYNC);
  assign w_data_byte = w_fire && (r_state == ST_DATA);

  prog_loader_word_pack #(
    .WORD_WIDTH (RAM_WORD_WIDTH)
  ) u_word_pack (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr      (w_sync),
    .i_byte_vld (w_data_byte),
    .i_byte     (bus.in_data),
    .o_last     (w_last),
    .o_word_vld (w_word_vld),
    .o_word     (w_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_addr     <= '0;
      r_wcnt     <= '0;
      r_cksum    <= '0;
      r_in_ready <= 1'b0;
      r_hold     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_in_ready <= 1'b1;
      r_done     <= 1'b0;

      // Address advances after each write; FF wraps to 00. A fresh ADDR
      // load can never coincide with a write, as CKSUM, SYNC and ADDR bytes
      // all sit between the last write of one frame and the next ADDR.
      if (w_word_vld) begin
        r_addr <= r_addr + 1'b1;
      end

      if (w_fire) begin
        case (r_state)
          ST_IDLE: begin
            if (bus.in_data == LOADER_SYNC) begin
              r_state <= ST_ADDR;
              r_err   <= 1'b0;
              r_hold  <= 1'b1;
              r_cksum <= '0;
            end
          end
          ST_ADDR: begin
            r_addr  <= bus.in_data[RAM_ADDR_BITS-1:0];
            r_state <= ST_COUNT;
          end
          ST_COUNT: begin
            r_wcnt  <= (bus.in_data == 8'h00) ? 9'd256 : {1'b0, bus.in_data};
            r_state <= ST_DATA;
          end
          ST_DATA: begin
            r_cksum <= r_cksum + bus.in_data;
            if (w_last) begin
              r_wcnt <= r_wcnt - 9'd1;
              if (r_wcnt == 9'd1) begin
                r_state <= ST_CKSUM;
              end
            end
          end
          ST_CKSUM: begin
            if (bus.in_data == r_cksum) begin
              r_done <= 1'b1;
            end else begin
              r_err <= 1'b1;
            end
            r_hold  <= 1'b0;
            r_state <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.in_ready = r_in_ready;
  assign bus.wr_en    = w_word_vld;
  assign bus.wr_addr  = r_addr;
  assign bus.wr_data  = w_word;
  assign bus.cpu_hold = r_hold;
  assign bus.done     = r_done;
  assign bus.err      = r_err;

endmodule

// File: tb/tb_prog_loader.sv
// Directed-frame bench for prog_loader with a frame-level reference model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_prog_loader;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  prog_loader_if #(.RAM_WORD_WIDTH(24), .RAM_ADDR_BITS(8)) bus();

  prog_loader #(.RAM_WORD_WIDTH(24), .RAM_ADDR_BITS(8)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: expectations for the cycle after the latest clock edge.
  bit          m_rdy, m_hold, m_err, m_exp_wr, m_exp_done;
  logic [7:0]  m_exp_addr;
  logic [23:0] m_exp_data;
  bit          m_in_frame;
  int          m_pos, m_nwords;
  logic [7:0]  m_base, m_sum;
  logic [23:0] m_word;

  // What the memory actually received.
  logic [23:0] shadow [256];
  bit          seen   [256];
  int          n_wr   = 0;
  int          n_done = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_rdy      = 1'b0;
    m_hold     = 1'b0;
    m_err      = 1'b0;
    m_exp_wr   = 1'b0;
    m_exp_done = 1'b0;
    m_in_frame = 1'b0;
  endfunction

  // Frame parser by byte position: header, data, then checksum.
  task automatic model_byte(input logic [7:0] b);
    if (!m_in_frame) begin
      if (b == 8'hA5) begin
        m_in_frame = 1'b1;
        m_pos      = 1;
        m_hold     = 1'b1;
        m_err      = 1'b0;
        m_sum      = 8'h00;
      end
    end else if (m_pos == 1) begin
      m_base = b;
      m_pos  = 2;
    end else if (m_pos == 2) begin
      m_nwords = (b == 8'h00) ? 256 : int'(b);
      m_pos    = 3;
    end else if (m_pos - 3 < m_nwords * 3) begin
      int k;
      k      = m_pos - 3;
      m_word = {m_word[15:0], b};
      m_sum  = m_sum + b;
      if (k % 3 == 2) begin
        m_exp_wr   = 1'b1;
        m_exp_addr = m_base + 8'(k / 3);
        m_exp_data = m_word;
      end
      m_pos++;
    end else begin
      if (b == m_sum) m_exp_done = 1'b1;
      else            m_err      = 1'b1;
      m_hold     = 1'b0;
      m_in_frame = 1'b0;
    end
  endtask

  // Every cycle: all outputs against the model.
  always @(negedge clk) begin
    chk("in_ready", 32'(bus.in_ready), 32'(m_rdy));
    chk("cpu_hold", 32'(bus.cpu_hold), 32'(m_hold));
    chk("err",      32'(bus.err),      32'(m_err));
    chk("done",     32'(bus.done),     32'(m_exp_done));
    chk("wr_en",    32'(bus.wr_en),    32'(m_exp_wr));
    if (bus.wr_en) begin
      if (m_exp_wr) begin
        chk("wr_addr", 32'(bus.wr_addr), 32'(m_exp_addr));
        chk("wr_data", 32'(bus.wr_data), 32'(m_exp_data));
      end
      shadow[bus.wr_addr] = bus.wr_data;
      seen[bus.wr_addr]   = 1'b1;
      n_wr++;
    end
    if (bus.done) n_done++;
    m_exp_wr   = 1'b0;
    m_exp_done = 1'b0;
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    @(posedge clk);
    if (m_rdy) model_byte(b);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_seq(input logic [7:0] s[$], input int gap_mod);
    for (int i = 0; i < s.size(); i++) begin
      send_byte(s[i]);
      if (gap_mod > 0) idle(i % gap_mod);
    end
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    m_rdy = 1'b1;
    #1;
  endtask

  logic [7:0] fr[$];
  int w0, d0, cnt;

  initial begin
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr_en",    32'(bus.wr_en),    0);
    chk("rst_wr_addr",  32'(bus.wr_addr),  0);
    chk("rst_wr_data",  32'(bus.wr_data),  0);
    chk("rst_cpu_hold", 32'(bus.cpu_hold), 0);
    chk("rst_done",     32'(bus.done),     0);
    chk("rst_err",      32'(bus.err),      0);
    chk("rst_in_ready", 32'(bus.in_ready), 0);
    release_reset();
    chk("ready_after_rst", 32'(bus.in_ready), 1);

    // Good two-word frame.
    w0 = n_wr; d0 = n_done;
    fr = '{8'hA5, 8'h10, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h15};
    send_seq(fr, 0);
    idle(2);
    chk("good_writes", 32'(n_wr - w0), 2);
    chk("good_done",   32'(n_done - d0), 1);
    chk("good_w0",     32'(shadow[8'h10]), 32'h010203);
    chk("good_w1",     32'(shadow[8'h11]), 32'h040506);
    chk("good_err",    32'(bus.err), 0);

    // Bad checksum: writes kept, err sticky, no done.
    w0 = n_wr; d0 = n_done;
    send_byte(8'hA5);
    chk("hold_after_sync", 32'(bus.cpu_hold), 1);
    fr = '{8'h10, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h16};
    send_seq(fr, 0);
    idle(5);
    chk("bad_writes", 32'(n_wr - w0), 2);
    chk("bad_done",   32'(n_done - d0), 0);
    chk("bad_err",    32'(bus.err), 1);
    chk("bad_hold",   32'(bus.cpu_hold), 0);

    // Idle garbage then a frame with 0..5-cycle gaps; DE+AD+BE = 0x249.
    w0 = n_wr; d0 = n_done;
    fr = '{8'h00, 8'h7F, 8'hA4, 8'hA5, 8'h40, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'h49};
    send_seq(fr, 6);
    idle(2);
    chk("gap_writes", 32'(n_wr - w0), 1);
    chk("gap_word",   32'(shadow[8'h40]), 32'hDEADBE);
    chk("gap_done",   32'(n_done - d0), 1);
    chk("gap_err",    32'(bus.err), 0);

    // Address wrap FF -> 00; AA+BB+CC+11+22+33 = 0x297, low byte 0x97.
    d0 = n_done;
    fr = '{8'hA5, 8'hFF, 8'h02, 8'hAA, 8'hBB, 8'hCC, 8'h11, 8'h22, 8'h33, 8'h97};
    send_seq(fr, 0);
    idle(2);
    chk("wrap_wFF", 32'(shadow[8'hFF]), 32'hAABBCC);
    chk("wrap_w00", 32'(shadow[8'h00]), 32'h112233);
    chk("wrap_done", 32'(n_done - d0), 1);

    // SYNC bytes inside the frame are data; 3*A5 = 0x1EF.
    d0 = n_done;
    fr = '{8'hA5, 8'h50, 8'h01, 8'hA5, 8'hA5, 8'hA5, 8'hEF};
    send_seq(fr, 0);
    idle(2);
    chk("sync_data_word", 32'(shadow[8'h50]), 32'hA5A5A5);
    chk("sync_data_done", 32'(n_done - d0), 1);

    // Reset after four data bytes of a two-word frame.
    w0 = n_wr;
    fr = '{8'hA5, 8'h20, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44};
    send_seq(fr, 0);
    rst_n = 1'b0;
    model_reset();
    #2;
    chk("midrst_hold",  32'(bus.cpu_hold), 0);
    chk("midrst_ready", 32'(bus.in_ready), 0);
    chk("midrst_wr_en", 32'(bus.wr_en), 0);
    release_reset();
    idle(3);
    chk("midrst_writes", 32'(n_wr - w0), 1);
    chk("midrst_w20",    32'(shadow[8'h20]), 32'h112233);
    chk("midrst_no_w21", 32'(seen[8'h21]), 0);
    d0 = n_done;
    fr = '{8'hA5, 8'h20, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h65};
    send_seq(fr, 0);
    idle(2);
    chk("reload_w21",  32'(shadow[8'h21]), 32'h445566);
    chk("reload_done", 32'(n_done - d0), 1);

    // COUNT=0: 256 words, data byte i = i mod 256, checksum 3*0x7F80 -> 0x80.
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    w0 = n_wr; d0 = n_done;
    fr = '{8'hA5, 8'h00, 8'h00};
    for (int i = 0; i < 768; i++) fr.push_back(8'(i));
    fr.push_back(8'h80);
    send_seq(fr, 0);
    idle(2);
    cnt = 0;
    for (int i = 0; i < 256; i++) if (seen[i]) cnt++;
    chk("full_writes",  32'(n_wr - w0), 256);
    chk("full_covered", 32'(cnt), 256);
    chk("full_w05",     32'(shadow[8'h05]), 32'h0F1011);
    chk("full_w64",     32'(shadow[8'h64]), 32'h2C2D2E);
    chk("full_done",    32'(n_done - d0), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
